// File: rtl/ram_access_unit_if.sv
// CPU-side request/response handshake plus the word-wide RAM port of ram_access_unit.
interface ram_access_unit_if #(
   parameter int ADDR_WIDTH = 16
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [31:0]           req_addr;
   logic [1:0]            req_size;
   logic                  req_unsigned;
   logic [31:0]           req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [31:0]           rsp_rdata;
   logic                  rsp_err;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [31:0]           ram_din;
   logic                  ram_we;
   logic [31:0]           ram_dout;

   modport slave (
      input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready, ram_dout,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_din, ram_we
   );

   modport master (
      output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready, ram_dout,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_din, ram_we
   );
endinterface

// File: rtl/ram_access_unit.sv
// Load/store front end for a sync-read word RAM: lane select, extension, RMW sub-word stores.
// Word store responds 1 cycle after accept, everything else 2; MISALIGN_TRAP_EN enables misalignment traps.
module ram_access_unit #(
   parameter int ADDR_WIDTH = 16
) (
   input logic              clk,
   input logic              rst,
   ram_access_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RD, RESP} state_t;

   typedef struct packed {
      logic                  we;
      logic [1:0]            size;
      logic                  uns;
      logic [1:0]            lane;
      logic [ADDR_WIDTH-1:0] widx;
      logic [31:0]           wdata;
   } req_t;

   state_t                state_q, state_d;
   req_t                  lat_q, req_in;
   logic [31:0]           rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  req_ready_c, accept, misalign;
   logic [ADDR_WIDTH-1:0] ram_addr_c;
   logic [31:0]           ram_din_c;
   logic                  ram_we_c;
   logic                  unused_addr_bits;

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = word[{lane[1], 4'b0000} +: 16];
      case (size)
         2'b00:   load_extend = uns ? {24'b0, b} : {{24{b[7]}}, b};
         2'b01:   load_extend = uns ? {16'b0, h} : {{16{h[15]}}, h};
         default: load_extend = word;
      endcase
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [1:0] size, input logic [1:0] lane);
      logic [31:0] r;
      r = word;
      case (size)
         2'b00:   r[{lane, 3'b000} +: 8] = wdata[7:0];
         2'b01:   r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         default: r = wdata;
      endcase
      store_merge = r;
   endfunction

   assign unused_addr_bits = ^bus.req_addr[31:ADDR_WIDTH+2];

`ifdef MISALIGN_TRAP_EN
   assign misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                     (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign req_in = '{we:    bus.req_we,
                     size:  bus.req_size,
                     uns:   bus.req_unsigned,
                     lane:  bus.req_addr[1:0],
                     widx:  bus.req_addr[ADDR_WIDTH+1:2],
                     wdata: bus.req_wdata};

   assign req_ready_c = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
   assign accept      = bus.req_valid && req_ready_c;

   always_comb begin
      state_d     = state_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      ram_addr_c  = lat_q.widx;
      ram_din_c   = '0;
      ram_we_c    = 1'b0;

      case (state_q)
         RD: begin
            // ram_dout now holds the word addressed in the accept cycle
            if (lat_q.we) begin
               ram_we_c    = 1'b1;
               ram_din_c   = store_merge(bus.ram_dout, lat_q.wdata, lat_q.size, lat_q.lane);
               rsp_rdata_d = '0;
            end else begin
               rsp_rdata_d = load_extend(bus.ram_dout, lat_q.size, lat_q.lane, lat_q.uns);
            end
            rsp_err_d = 1'b0;
            state_d   = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: ;
      endcase

      // An accept in RESP overrides the return to IDLE, giving back-to-back service
      if (accept) begin
         ram_addr_c = req_in.widx;
         if (misalign) begin
            state_d     = RESP;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
         end else if (req_in.we && req_in.size[1]) begin
            ram_we_c    = 1'b1;
            ram_din_c   = req_in.wdata;
            state_d     = RESP;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
         end else begin
            state_d = RD;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         lat_q       <= '0;
      end else begin
         state_q     <= state_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         if (accept) lat_q <= req_in;
      end
   end

   assign bus.req_ready = req_ready_c;
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.ram_addr  = ram_addr_c;
   assign bus.ram_din   = ram_din_c;
   // Reset cancels any merge write still pending in RD
   assign bus.ram_we    = ram_we_c & ~rst;

endmodule

// File: doc/ram_access_unit.md
Name: ram_access_unit

Overview:
- Request/response front end that sits directly upstream of the single-port synchronous-read data RAM.
- Converts CPU load/store requests into word-wide RAM accesses:
  - byte/halfword lane select with sign/zero extension on loads;
  - read-modify-write for sub-word stores, because the RAM has a whole-word write enable only.
- Hides the RAM's one-cycle registered-address read latency behind a valid/ready handshake towards the memory pipeline stage.

Parameters:
ADDR_WIDTH, 16, RAM word-address width; RAM depth 2^ADDR_WIDTH words of 32 bits

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request valid
req_ready  output  1  request accepted when req_valid && req_ready
req_we  input  1  1=store, 0=load
req_addr  input  32  byte address; word index = req_addr[ADDR_WIDTH+1:2]
req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
req_unsigned  input  1  loads: 1=zero-extend, 0=sign-extend
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  output  32  extended load data; 0 for stores
rsp_err  output  1  misaligned-access error (see Optional Feature)
ram_addr  output  ADDR_WIDTH  RAM word address
ram_din  output  32  RAM write data
ram_we  output  1  RAM write enable
ram_dout  input  32  RAM read data, valid the cycle after ram_addr is presented

Behaviour:
- States: IDLE, RD, RESP.
- Reset (sync, rst=1): state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, latched address/size/data=0; ram_we forced 0 while rst=1.
- req_ready = (state==IDLE) || (state==RESP && rsp_ready). A request accepted in RESP behaves exactly like an IDLE accept, giving back-to-back operation.
- Accept cycle (cycle 0): ram_addr driven combinationally from req_addr word index. Otherwise ram_addr = latched word index.
- Word store: ram_we=1 and ram_din=req_wdata in cycle 0 → RESP. rsp_valid=1 in cycle 1, rsp_rdata=0.
- Load or sub-word store: cycle 0 → RD (RAM registers address). In RD, ram_dout is valid:
  - load: extract lane, extend, register into rsp_rdata → RESP; rsp_valid=1 in cycle 2;
  - sub-word store: ram_din = ram_dout with lane replaced by wdata; ram_we=1 for exactly this one cycle (ram_addr held) → RESP; rsp_valid=1 in cycle 2.
- Lane select:
  - byte lane = addr[1:0];
  - half lane = addr[1] (bits [15:0] or [31:16]);
  - word ignores addr[1:0].
- RESP: rsp_valid, rsp_rdata and rsp_err held stable until rsp_ready. On handshake without a new accept → IDLE, rsp_valid=0.
- A store response is issued only after its RAM write cycle, so a following load always observes the stored data.
- Reset mid-operation: rst in RD suppresses the pending merge write (RAM word unchanged). rsp_valid=0 the next cycle.
- No RAM access (ram_we=0) in any cycle other than the ones listed above.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - a half with addr[0]=1, or a word with addr[1:0]!=0, is accepted but performs no RAM read or write;
  - → RESP with rsp_valid in cycle 1, rsp_err=1, rsp_rdata=0.
  - rsp_err=0 for all aligned accesses.
- Undefined:
  - offending low address bits are ignored per the lane-select rules;
  - rsp_err is constant 0.

Test Plan:
- RAM[4]=0x11223344, RAM[5]=0x8899AABB:
  - lb 0x13 → 0x00000011;
  - lb 0x14 → 0xFFFFFFBB;
  - lbu 0x14 → 0x000000BB;
  - lh 0x16 → 0xFFFF8899;
  - lhu 0x16 → 0x00008899;
  - each with rsp_valid exactly 2 cycles after accept.
- sb 0x11 wdata 0x000000EE on RAM[4]=0x11223344 → ram_we high for one cycle (cycle 1), RAM[4]=0x1122EE44. Subsequent lw 0x10 → 0x1122EE44.
- sw 0x20 wdata 0xDEADBEEF → ram_we in accept cycle, rsp_valid in cycle 1 with rsp_rdata=0. lw 0x20 → 0xDEADBEEF.
- Backpressure:
  - rsp_ready=0 for 5 cycles → rsp_valid/rsp_rdata stable, req_ready=0;
  - then rsp_ready=1 with req_valid=1 → new request accepted in the same cycle, no idle bubble.
- sh 0x12 wdata 0x5555 with rst asserted during RD → no ram_we, rsp_valid=0 next cycle, RAM[4] unchanged.
- lw 0x12:
  - with MISALIGN_TRAP_EN → rsp_err=1, rsp_rdata=0, no RAM access;
  - without → rsp_rdata=RAM[4], rsp_err=0.
